// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request on the instruction bus,
// with delay-slot aware redirect handling and exception flush/cancel.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc,
    input  logic        branchD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instrF,
    output logic [31:0] F_change,
    output logic        validF,
    output logic        i_stall
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_CANCEL} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_q, buf_nxt;
    logic        redir_v, redir_v_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic [31:0] seq_pc;
    logic        advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            buf_q    <= '0;
            redir_v  <= 1'b0;
            redir_pc <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            buf_q    <= buf_nxt;
            redir_v  <= redir_v_nxt;
            redir_pc <= redir_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        buf_nxt      = buf_q;
        redir_v_nxt  = redir_v;
        redir_pc_nxt = redir_pc;
        inst_req     = 1'b0;
        validF       = 1'b0;
        i_stall      = 1'b1;
        instrF       = buf_q;
        advance      = 1'b0;

        if (redirect) begin
            redir_v_nxt  = 1'b1;
            redir_pc_nxt = redirect_pc;
        end
        // A redirect arriving while the delay slot leaves fetch is taken at once
        seq_pc = redirect ? redirect_pc : (redir_v ? redir_pc : pc + 32'd4);

        case (state)
            S_REQ: begin
                inst_req = 1'b1;
                if (exc_flush) begin
                    // pc holds the exception target while CANCEL drains the old request
                    redir_v_nxt = 1'b0;
                    pc_nxt      = exc_pc;
                    if (inst_addr_ok) state_nxt = S_CANCEL;
                end else if (inst_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                instrF  = inst_rdata;
                i_stall = ~inst_data_ok;
                if (exc_flush) begin
                    redir_v_nxt = 1'b0;
                    pc_nxt      = exc_pc;
                    state_nxt   = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    validF  = 1'b1;
                    buf_nxt = inst_rdata;
                    if (stallF) state_nxt = S_HOLD;
                    else        advance   = 1'b1;
                end
            end
            S_HOLD: begin
                validF  = 1'b1;
                i_stall = 1'b0;
                if (exc_flush) begin
                    redir_v_nxt = 1'b0;
                    pc_nxt      = exc_pc;
                    state_nxt   = S_REQ;
                end else if (!stallF) begin
                    advance = 1'b1;
                end
            end
            S_CANCEL: begin
                if (exc_flush) begin
                    redir_v_nxt = 1'b0;
                    pc_nxt      = exc_pc;
                end
                if (inst_data_ok) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase

        if (advance) begin
            pc_nxt      = seq_pc;
            redir_v_nxt = 1'b0;
            state_nxt   = S_REQ;
        end
    end

    assign inst_addr = pc;
    assign pcF       = pc;
    assign pc_plus4F = pc + 32'd4;
    assign F_change  = {31'b0, branchD & validF};

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: bus responder, random pipeline controls and
// a program-order scoreboard of the next PC expected to be presented.
module tb_inst_fetch;

    localparam logic [31:0] RPC    = 32'hBFC0_0000;
    localparam int unsigned NCYC   = 4000;

    logic        clk = 1'b0;
    logic        rst, stallF, redirect, exc_flush, branchD;
    logic [31:0] redirect_pc, exc_pc;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [31:0] pcF, pc_plus4F, instrF, F_change;
    logic        validF, i_stall;

    int unsigned checks = 0;
    int unsigned errors = 0;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect),
        .redirect_pc(redirect_pc), .exc_flush(exc_flush), .exc_pc(exc_pc),
        .branchD(branchD), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .pcF(pcF), .pc_plus4F(pc_plus4F),
        .instrF(instrF), .F_change(F_change), .validF(validF), .i_stall(i_stall)
    );

    always #5 clk = ~clk;

    // Memory image: each address holds a distinct word.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C1D_0B07;
    endfunction

    function automatic logic [31:0] pick_target();
        int unsigned r;
        logic [31:0] t;
        r = $urandom_range(0, 9);
        t = $urandom();
        if (r == 0)      return 32'hFFFF_FFFC;
        else if (r < 4)  return RPC + 32'h100;
        else             return {t[31:2], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Driver and bus responder, all inputs change on the falling edge.
    initial begin : drive
        logic        outstanding, acc_drv;
        logic [31:0] oaddr, acc_addr;
        int unsigned lat;
        outstanding = 1'b0; acc_drv = 1'b0; oaddr = '0; acc_addr = '0; lat = 0;
        rst = 1'b1; stallF = 1'b0; redirect = 1'b0; exc_flush = 1'b0; branchD = 1'b0;
        redirect_pc = '0; exc_pc = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        for (int unsigned c = 0; c < NCYC; c++) begin
            @(negedge clk);
            if (rst) begin
                outstanding = 1'b0;
            end else begin
                if (inst_data_ok) outstanding = 1'b0;
                if (acc_drv) begin
                    outstanding = 1'b1;
                    oaddr       = acc_addr;
                    lat         = $urandom_range(0, 2);
                end
            end
            rst         = (c < 2) || ($urandom_range(0, 299) == 0);
            stallF      = ($urandom_range(0, 3) == 0);
            branchD     = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = pick_target();
            exc_flush   = ($urandom_range(0, 24) == 0);
            exc_pc      = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0380 : pick_target();
            inst_addr_ok = inst_req && ($urandom_range(0, 2) != 0);
            acc_drv      = inst_addr_ok;
            acc_addr     = inst_addr;
            if (outstanding && lat == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = memf(oaddr);
            end else begin
                inst_data_ok = 1'b0;
                inst_rdata   = $urandom();
                if (outstanding) lat--;
            end
        end
        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Scoreboard: exp_q holds the PC of the next instruction in program order.
    logic [31:0] exp_q[$];
    logic        pend_v = 1'b0;
    logic [31:0] pend_pc = '0;
    logic        chk_rst = 1'b0;
    logic        hold_prev = 1'b0;
    int unsigned idle = 0;

    always @(negedge clk) begin : monitor
        logic [31:0] front, nxt;
        #2;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RPC);
            pend_v    = 1'b0;
            chk_rst   = 1'b1;
            hold_prev = 1'b0;
            idle      = 0;
        end else begin
            front = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
            if (chk_rst) begin
                chk("rst_req", {31'b0, inst_req}, 32'd1);
                chk("rst_addr", inst_addr, RPC);
                chk("rst_valid", {31'b0, validF}, 32'd0);
                chk("rst_fchange", F_change, 32'd0);
                chk_rst = 1'b0;
            end
            if (hold_prev) begin
                chk("hold_valid", {31'b0, validF}, 32'd1);
                chk("hold_noreq", {31'b0, inst_req}, 32'd0);
            end
            if (validF) begin
                chk("pcF", pcF, front);
                chk("instrF", instrF, memf(front));
                chk("pc_plus4F", pc_plus4F, front + 32'd4);
                chk("F_change", F_change, {31'b0, branchD});
                idle = 0;
            end else begin
                chk("F_change_idle", F_change, 32'd0);
                idle++;
                if (idle == 40) begin
                    errors++;
                    $display("FAIL watchdog actual=no_valid_for_%0d_cycles required=progress", idle);
                    idle = 0;
                end
            end
            if (!exc_flush) chk("i_stall", {31'b0, i_stall}, {31'b0, ~validF});
            if (inst_req && inst_addr_ok) chk("inst_addr", inst_addr, front);
            hold_prev = validF && stallF && !exc_flush;

            if (exc_flush) begin
                exp_q.delete();
                exp_q.push_back(exc_pc);
                pend_v = 1'b0;
            end else begin
                if (redirect) begin
                    pend_v  = 1'b1;
                    pend_pc = redirect_pc;
                end
                if (validF && !stallF) begin
                    void'(exp_q.pop_front());
                    nxt = pend_v ? pend_pc : front + 32'd4;
                    exp_q.push_back(nxt);
                    pend_v = 1'b0;
                end
            end
        end
    end

endmodule
